// File: rtl/decoder_onehot_seq_pkg.sv
// Shared types and the reference one-hot helper for the registered decoder family.
package decoder_pkg;

  // Widest address the helper supports; instances must keep SEL_W at or below this.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LEVEL = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_SCAN  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_STROBE,
    ST_SCAN
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input int sel_w);
    logic [MAX_OUT_W-1:0] vec;
    vec = '0;
    if (sel_w <= MAX_SEL_W && int'(sel) < (1 << sel_w)) vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decoder_onehot_seq_comb.sv
// Purely combinational SEL_W-to-OUT_W one-hot decoder; all-zero outside the decoded line.
module decoder_onehot_comb
  import decoder_pkg::*;
#(
  parameter  int SEL_W = 5,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] decoded
);

  logic [MAX_OUT_W-1:0] full;

  always_comb full = onehot(MAX_SEL_W'(sel), SEL_W);

  assign decoded = full[OUT_W-1:0];

  // Lines above OUT_W can never be hot for a SEL_W-bit address.
  if (OUT_W < MAX_OUT_W) begin : g_hi_sink
    logic unused_hi;
    assign unused_hi = ^full[MAX_OUT_W-1:OUT_W];
  end

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with held, single-cycle strobe and auto-incrementing scan modes.
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W     = 5,
  parameter  int ZERO_MASK = 0,
  localparam int OUT_W     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             stop,
  output logic [OUT_W-1:0] decoded,
  output logic [SEL_W-1:0] index,
  output logic             busy,
  output logic             wrap
);

  mode_e            mode_c;
  state_e           state;
  state_e           state_next;
  logic [SEL_W-1:0] index_next;
  logic             wrap_next;
  logic [OUT_W-1:0] line_hot;
  logic [OUT_W-1:0] decoded_next;

  assign mode_c = mode_e'(mode);

  // State and output registers; every output leaves straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      index   <= '0;
      decoded <= '0;
      wrap    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state   <= state_next;
      index   <= index_next;
      decoded <= decoded_next;
      wrap    <= wrap_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mode_c == MODE_LEVEL && en)                     state_next = ST_HOLD;
        else if (mode_c == MODE_PULSE && en)                state_next = ST_STROBE;
        else if (mode_c == MODE_SCAN && start && !stop)     state_next = ST_SCAN;
      end
      ST_HOLD:   if (mode_c != MODE_LEVEL)                  state_next = ST_IDLE;
      ST_STROBE: if (!(mode_c == MODE_PULSE && en))         state_next = ST_IDLE;
      ST_SCAN:   if (stop || mode_c != MODE_SCAN)           state_next = ST_IDLE;
      default:                                              state_next = ST_IDLE;
    endcase
  end

  // Line selection: capture sel on entry/reload, step through lines while scanning.
  always_comb begin
    index_next = index;
    wrap_next  = 1'b0;
    case (state)
      ST_SCAN: begin
        if (state_next == ST_SCAN) begin
          index_next = index + SEL_W'(1);
          wrap_next  = (index == '1);
        end
      end
      default: begin
        if (state_next != ST_IDLE && (state == ST_IDLE || en)) index_next = sel;
      end
    endcase
  end

  decoder_onehot_comb #(.SEL_W(SEL_W)) u_dec (
    .sel     (index_next),
    .decoded (line_hot)
  );

  always_comb begin
    decoded_next = '0;
    if (state_next != ST_IDLE) begin
      decoded_next = line_hot;
      if (ZERO_MASK != 0) decoded_next[0] = 1'b0;
    end
  end

  assign busy = (state == ST_SCAN);

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(decoded));
  a_wrap_at_zero: assert property (@(posedge clk) disable iff (rst) wrap |-> (busy && index == '0));

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_decoder_onehot_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [4:0] sel;
  logic       start;
  logic       stop;

  logic [31:0] dec5, decz;
  logic [4:0]  idx5, idxz;
  logic        busy5, busyz, wrap5, wrapz;
  logic [7:0]  dec3;
  logic [2:0]  idx3;
  logic        busy3, wrap3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq #(.SEL_W(5), .ZERO_MASK(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start), .stop(stop),
    .decoded(dec5), .index(idx5), .busy(busy5), .wrap(wrap5)
  );

  decoder_onehot_seq #(.SEL_W(5), .ZERO_MASK(1)) dut_zm (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start), .stop(stop),
    .decoded(decz), .index(idxz), .busy(busyz), .wrap(wrapz)
  );

  decoder_onehot_seq #(.SEL_W(3), .ZERO_MASK(0)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .start(start), .stop(stop),
    .decoded(dec3), .index(idx3), .busy(busy3), .wrap(wrap3)
  );

  // Model: which line is lit, whether it is held or sweeping, and whether it just wrapped.
  typedef struct {
    int line;
    bit lit;
    bit held;
    bit scanning;
    bit wrapped;
  } model_t;

  model_t m5, mz, m3;

  function automatic model_t model_reset();
    model_t m;
    m.line = 0; m.lit = 0; m.held = 0; m.scanning = 0; m.wrapped = 0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, int w, bit en_i, int mode_i, int sel_i,
                                        bit start_i, bit stop_i);
    model_t n;
    int lines;
    int s;
    lines = 1 << w;
    s = sel_i % lines;
    n = m;
    n.wrapped = 0;
    if (m.scanning) begin
      if (stop_i || mode_i != 3) begin
        n.scanning = 0;
        n.lit = 0;
      end else begin
        n.line = (m.line + 1) % lines;
        n.wrapped = (n.line == 0);
      end
    end else if (m.lit && m.held) begin
      if (mode_i != 1) begin
        n.lit = 0;
        n.held = 0;
      end else if (en_i) n.line = s;
    end else if (m.lit) begin
      if (mode_i == 2 && en_i) n.line = s;
      else n.lit = 0;
    end else begin
      if (mode_i == 1 && en_i) begin
        n.lit = 1; n.held = 1; n.line = s;
      end else if (mode_i == 2 && en_i) begin
        n.lit = 1; n.line = s;
      end else if (mode_i == 3 && start_i && !stop_i) begin
        n.lit = 1; n.scanning = 1; n.line = s;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] model_dec(model_t m, bit zm);
    if (!m.lit || (zm && m.line == 0)) return 64'd0;
    return 64'd1 << m.line;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("dec5",  64'(dec5),  model_dec(m5, 0));
    check("idx5",  64'(idx5),  64'(m5.line));
    check("busy5", 64'(busy5), 64'(m5.scanning));
    check("wrap5", 64'(wrap5), 64'(m5.wrapped));
    check("decz",  64'(decz),  model_dec(mz, 1));
    check("idxz",  64'(idxz),  64'(mz.line));
    check("busyz", 64'(busyz), 64'(mz.scanning));
    check("wrapz", 64'(wrapz), 64'(mz.wrapped));
    check("dec3",  64'(dec3),  model_dec(m3, 0));
    check("idx3",  64'(idx3),  64'(m3.line));
    check("busy3", 64'(busy3), 64'(m3.scanning));
    check("wrap3", 64'(wrap3), 64'(m3.wrapped));
  endtask

  // One clock: models consume the inputs present at the edge, outputs checked 1 ns later.
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      m5 = model_next(m5, 5, en, int'(mode), int'(sel), start, stop);
      mz = model_next(mz, 5, en, int'(mode), int'(sel), start, stop);
      m3 = model_next(m3, 3, en, int'(mode), int'(sel), start, stop);
    end
    #1;
    compare_all();
  endtask

  // Called 1 ns after an edge: pulses rst well clear of both clock edges.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    m5 = model_reset();
    mz = model_reset();
    m3 = model_reset();
    compare_all();
    #1 rst = 1'b0;
  endtask

  task automatic idle_inputs();
    mode = 2'd0; en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sel = '0;
    idle_inputs();
    m5 = model_reset();
    mz = model_reset();
    m3 = model_reset();
    #3;
    compare_all();
    @(negedge clk) rst = 1'b0;

    // Held level output, then reload with no dead cycle.
    mode = 2'd1; en = 1'b1; sel = 5'd7;
    cycle();
    check("lvl7", 64'(dec5), 64'h80);
    en = 1'b0; sel = 5'd9;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("lvl7_hold", 64'(dec5), 64'h80);
    end
    en = 1'b1; sel = 5'd31;
    cycle();
    check("lvl31", 64'(dec5), 64'h8000_0000);
    idle_inputs();
    cycle();

    // Back-to-back strobes.
    mode = 2'd2; en = 1'b1; sel = 5'd3;
    cycle();
    check("pulse3", 64'(dec5), 64'h8);
    sel = 5'd4;
    cycle();
    check("pulse4", 64'(dec5), 64'h10);
    en = 1'b0;
    cycle();
    check("pulse_end", 64'(dec5), 64'h0);
    idle_inputs();
    cycle();

    // Scan across the wrap, then stop.
    mode = 2'd3; sel = 5'd30; start = 1'b1;
    cycle();
    check("scan30", 64'(idx5), 64'd30);
    check("scan30_busy", 64'(busy5), 64'd1);
    start = 1'b0;
    cycle();
    check("scan31", 64'(idx5), 64'd31);
    check("scan31_wrap", 64'(wrap5), 64'd0);
    cycle();
    check("scan0", 64'(idx5), 64'd0);
    check("scan0_wrap", 64'(wrap5), 64'd1);
    check("scan0_dec", 64'(dec5), 64'h1);
    cycle();
    check("scan1", 64'(idx5), 64'd1);
    check("scan1_wrap", 64'(wrap5), 64'd0);
    stop = 1'b1;
    cycle();
    check("stop_dec", 64'(dec5), 64'h0);
    check("stop_busy", 64'(busy5), 64'd0);
    check("stop_idx", 64'(idx5), 64'd1);
    idle_inputs();
    cycle();

    // Hardwired-zero line: level on line 0 and a scan through line 0.
    mode = 2'd1; en = 1'b1; sel = 5'd0;
    cycle();
    check("zm_lvl0_dec", 64'(decz), 64'h0);
    check("zm_lvl0_idx", 64'(idxz), 64'd0);
    check("lvl0_dec", 64'(dec5), 64'h1);
    idle_inputs();
    cycle();
    mode = 2'd3; sel = 5'd31; start = 1'b1;
    cycle();
    check("zm_scan31", 64'(decz), 64'h8000_0000);
    start = 1'b0;
    cycle();
    check("zm_scan0", 64'(decz), 64'h0);
    check("zm_scan0_busy", 64'(busyz), 64'd1);
    cycle();
    check("zm_scan1", 64'(decz), 64'h2);
    idle_inputs();
    cycle();

    // Asynchronous reset in the middle of a scan.
    mode = 2'd3; sel = 5'd10; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check("scan12", 64'(idx5), 64'd12);
    async_reset();
    check("rst_dec", 64'(dec5), 64'h0);
    check("rst_busy", 64'(busy5), 64'd0);
    sel = 5'd0; start = 1'b1;
    cycle();
    check("post_rst_dec", 64'(dec5), 64'h1);
    idle_inputs();
    cycle();

    // start and stop together: stop wins.
    mode = 2'd3; start = 1'b1; stop = 1'b1; sel = 5'd5;
    cycle();
    check("ss_busy", 64'(busy5), 64'd0);
    check("ss_dec", 64'(dec5), 64'h0);
    idle_inputs();
    cycle();

    // Narrow instance.
    mode = 2'd1; en = 1'b1; sel = 5'd6;
    cycle();
    check("w3_lvl6", 64'(dec3), 64'h40);
    idle_inputs();
    cycle();

    // Randomized traffic with sticky modes so scans run long enough to wrap.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) mode = 2'($urandom_range(3));
      en    = 1'($urandom_range(1));
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(15) == 0);
      sel   = 5'($urandom);
      if ($urandom_range(199) == 0) async_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
